uart_color_cmd: RTL and testbench
=================================

// Module: uart_color_cmd
// PURPOSE
//  Byte-stream command parser between the UART receiver and the video colour path.
//  Accepts ASCII lines "RRGGBB\n" (6 hex digits, web order) from uart_rx.
//  On a valid line it updates the 24-bit {B,G,R} fill colour consumed by the pixel stage,
//  and it returns a one-byte ACK to uart_tx: 'K' for a good line, 'E' for a bad one.
//  Malformed or stalled lines are discarded; the last good colour stays on O_color.
// PARAMETERS
//  ACK_OK          8'h4B       byte sent after a valid line ('K')
//  ACK_ERR         8'h45       byte sent after an invalid line ('E')
//  TERM_CHAR       8'h0A       line terminator (LF)
//  IGNORE_CHAR     8'h0D       byte dropped without effect (CR)
//  TIMEOUT_CYCLES  27_000_000  idle cycles before a partial line is discarded; 0 = disabled
// PORTS
//  I_clk         in   1   system clock (27 MHz); only clock
//  I_rst         in   1   asynchronous active-high reset
//  I_rx_data     in   8   byte from uart_rx
//  I_rx_valid    in   1   I_rx_data valid
//  O_rx_ready    out  1   byte accepted when I_rx_valid & O_rx_ready at posedge
//  O_tx_data     out  8   ACK byte to uart_tx
//  O_tx_valid    out  1   O_tx_data valid; held until I_tx_ready
//  I_tx_ready    in   1   uart_tx can take a byte
//  O_color       out  24  current colour {B[23:16],G[15:8],R[7:0]}
//  O_color_stb   out  1   1-cycle pulse in the cycle O_color changes
// BEHAVIOUR
//  Reset (async, I_rst=1): O_color=0, O_color_stb=0, O_tx_valid=0, O_tx_data=0, O_rx_ready=0.
//  Reset also clears acc[23:0], cnt[2:0], err and the timeout counter; state=RECV.
//  Reset mid-line or mid-ACK discards all pending work. No ACK is sent after reset.
//  FSM RECV: O_rx_ready=1.
//   Hex digit ('0'-'9','A'-'F','a'-'f'):
//    if cnt<6: acc<={acc[19:0],nib}, cnt++.
//    else: err<=1 (7th+ digit); acc and cnt unchanged.
//   IGNORE_CHAR: no effect except timeout restart.
//   Any other non-TERM byte: err<=1.
//   TERM_CHAR with cnt==0 and !err (empty line): ignored; no ACK, stay RECV.
//   TERM_CHAR, cnt==6, !err: at next edge O_color<={acc[7:0],acc[15:8],acc[23:16]},
//    O_color_stb=1 for that one cycle, O_tx_data=ACK_OK, O_tx_valid=1, go ACK.
//   TERM_CHAR otherwise: O_tx_data=ACK_ERR, O_tx_valid=1, go ACK; O_color unchanged, no stb.
//   Any TERM_CHAR clears acc, cnt and err.
//  FSM ACK: O_rx_ready=0 (incoming bytes are not consumed).
//   O_tx_valid and O_tx_data held stable until I_tx_ready=1 at a posedge.
//   At that edge O_tx_valid<=0, go RECV; O_rx_ready=1 from the following cycle.
//  Latency: TERM accepted at edge N -> O_color/O_color_stb/O_tx_valid valid after edge N.
//   Minimum 2 cycles from TERM to the next accepted byte.
//  Timeout (TIMEOUT_CYCLES>0):
//   32-bit counter in RECV; cleared on every accepted byte.
//   Increments only while line is partial (cnt>0 or err).
//   On reaching TIMEOUT_CYCLES: clear acc, cnt, err and counter. Silent: no ACK, no colour change.
//   A byte accepted in the same cycle the timeout fires is processed against the cleared line.
//  Widths: cnt saturates at 6; acc is 24 bits exactly; no arithmetic wrap is possible.
//  O_color is I_clk-domain and changes only on O_color_stb; the pixel-clock consumer synchronises it.
// TESTING
//  1. Reset, send "FF8000\n" with I_tx_ready=1 -> O_color=24'h0080FF, one O_color_stb, tx byte 8'h4B.
//  2. Send "ff8000\r\n" -> same as test 1 (lowercase hex accepted, CR ignored).
//  3. After test 1, send "12345\n" then "1234567\n" then "12G456\n" -> three 8'h45 ACKs, O_color stays 24'h0080FF, no stb.
//  4. Send "\n" alone -> no tx byte, no stb, O_rx_ready remains 1.
//  5. Hold I_tx_ready=0 for 50 cycles after "000001\n" -> O_tx_valid=1 and O_tx_data=8'h4B stable,
//     O_rx_ready=0 for all 50 cycles; release -> one transfer, then RECV; O_color=24'h010000.
//  6. TIMEOUT_CYCLES=100: send "AB", idle 100 cycles, send "CDEF01\n" -> 8'h4B, O_color=24'h01EFCD.
//     Assert I_rst during an ACK wait -> O_tx_valid=0 and O_color=0 immediately (async).

Source files
------------

// File: rtl/uart_color_cmd.sv
// rtl/uart_color_cmd.sv - ASCII "RRGGBB\n" colour command parser with K/E acknowledge
//
// Purpose: parses hex colour lines arriving from uart_rx, updates the {B,G,R}
// fill colour on a good line and returns a one-byte ACK ('K' good, 'E' bad)
// to uart_tx. Partial lines idle for TIMEOUT_CYCLES are silently dropped.
//
// Ports:
//   I_clk        system clock
//   I_rst        asynchronous active-high reset
//   I_rx_data    byte from uart_rx
//   I_rx_valid   I_rx_data valid
//   O_rx_ready   byte accepted on I_rx_valid & O_rx_ready
//   O_tx_data    ACK byte to uart_tx
//   O_tx_valid   O_tx_data valid, held until I_tx_ready
//   I_tx_ready   uart_tx can take a byte
//   O_color      current colour {B[23:16],G[15:8],R[7:0]}
//   O_color_stb  one-cycle pulse when O_color changes
module uart_color_cmd #(
   parameter logic [7:0]  ACK_OK         = 8'h4B,
   parameter logic [7:0]  ACK_ERR        = 8'h45,
   parameter logic [7:0]  TERM_CHAR      = 8'h0A,
   parameter logic [7:0]  IGNORE_CHAR    = 8'h0D,
   parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic [7:0]  I_rx_data,
   input  logic        I_rx_valid,
   output logic        O_rx_ready,
   output logic [7:0]  O_tx_data,
   output logic        O_tx_valid,
   input  logic        I_tx_ready,
   output logic [23:0] O_color,
   output logic        O_color_stb
);

   typedef enum logic {S_RECV, S_ACK} state_t;

   localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   state_t      state, state_nx;
   logic [23:0] acc, acc_l;
   logic [2:0]  cnt, cnt_l;
   logic        err, err_l;
   logic [31:0] tcnt;

   logic       accept, is_hex, is_term, is_ign;
   logic [3:0] nib;
   logic       partial, fire, line_good, line_bad;

   // Hex digit decode: letters map via low nibble + 9 ('A'=0x41 -> 10)
   always_comb begin
      is_hex = 1'b0;
      nib    = I_rx_data[3:0];
      if (I_rx_data >= 8'h30 && I_rx_data <= 8'h39) begin
         is_hex = 1'b1;
      end else if ((I_rx_data >= 8'h41 && I_rx_data <= 8'h46) ||
                   (I_rx_data >= 8'h61 && I_rx_data <= 8'h66)) begin
         is_hex = 1'b1;
         nib    = I_rx_data[3:0] + 4'd9;
      end
   end

   // O_rx_ready is only high in RECV, so it alone qualifies acceptance
   always_comb begin
      accept  = O_rx_ready && I_rx_valid;
      is_term = accept && (I_rx_data == TERM_CHAR);
      is_ign  = I_rx_data == IGNORE_CHAR;
      partial = (cnt != 3'd0) || err;
      fire    = TO_EN && (state == S_RECV) && partial && (tcnt == TO_LAST);
      // Line as seen by this cycle's byte: a firing timeout empties it first
      acc_l   = fire ? 24'd0 : acc;
      cnt_l   = fire ? 3'd0  : cnt;
      err_l   = fire ? 1'b0  : err;
      line_good = is_term && (cnt_l == 3'd6) && !err_l;
      line_bad  = is_term && !line_good && ((cnt_l != 3'd0) || err_l);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_RECV:  if (line_good || line_bad) state_nx = S_ACK;
         S_ACK:   if (I_tx_ready) state_nx = S_RECV;
         default: state_nx = S_RECV;
      endcase
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) state <= S_RECV;
      else       state <= state_nx;
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         O_rx_ready  <= 1'b0;
         O_tx_data   <= 8'h00;
         O_tx_valid  <= 1'b0;
         O_color     <= 24'h000000;
         O_color_stb <= 1'b0;
         acc         <= 24'h000000;
         cnt         <= 3'd0;
         err         <= 1'b0;
         tcnt        <= 32'd0;
      end else begin
         O_rx_ready  <= (state_nx == S_RECV);
         O_color_stb <= 1'b0;
         acc         <= acc_l;
         cnt         <= cnt_l;
         err         <= err_l;

         if (accept) begin
            if (is_term) begin
               acc <= 24'h000000;
               cnt <= 3'd0;
               err <= 1'b0;
            end else if (is_hex) begin
               if (cnt_l < 3'd6) begin
                  acc <= {acc_l[19:0], nib};
                  cnt <= cnt_l + 3'd1;
               end else begin
                  err <= 1'b1;
               end
            end else if (!is_ign) begin
               err <= 1'b1;
            end
         end

         // Idle counter only runs while a line is partially received
         if (accept || fire)
            tcnt <= 32'd0;
         else if (TO_EN && (state == S_RECV) && partial)
            tcnt <= tcnt + 32'd1;

         // acc holds R,G,B in web order from MSB; output is {B,G,R}
         if (line_good) begin
            O_color     <= {acc_l[7:0], acc_l[15:8], acc_l[23:16]};
            O_color_stb <= 1'b1;
            O_tx_data   <= ACK_OK;
            O_tx_valid  <= 1'b1;
         end else if (line_bad) begin
            O_tx_data   <= ACK_ERR;
            O_tx_valid  <= 1'b1;
         end else if ((state == S_ACK) && I_tx_ready) begin
            O_tx_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_color_cmd.sv
// tb/tb_uart_color_cmd.sv - scoreboard bench for uart_color_cmd with directed and random lines
`timescale 1ns/1ps
module tb_uart_color_cmd;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [23:0] color;
   logic        color_stb;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int rdy_mode = 1;
   int last_t = 0;

   logic [7:0]  tx_exp[$];
   logic [23:0] col_exp[$];
   logic [7:0]  line[$];

   uart_color_cmd #(.TIMEOUT_CYCLES(TO)) dut (
      .I_clk(clk), .I_rst(rst),
      .I_rx_data(rx_data), .I_rx_valid(rx_valid), .O_rx_ready(rx_ready),
      .O_tx_data(tx_data), .O_tx_valid(tx_valid), .I_tx_ready(tx_ready),
      .O_color(color), .O_color_stb(color_stb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int hexval(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
      if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
      if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
      return -1;
   endfunction

   // Reference model: whole-line evaluation at the terminator
   task automatic model_byte(input logic [7:0] b, input int t);
      int digits, v;
      bit bad, part;
      part = 0;
      foreach (line[i]) if (line[i] != 8'h0D) part = 1;
      if (part && (t - last_t) >= TO) line.delete();
      last_t = t;
      if (b != 8'h0A) begin
         line.push_back(b);
         return;
      end
      digits = 0; bad = 0; v = 0;
      foreach (line[i]) begin
         if (hexval(line[i]) >= 0) begin
            digits++;
            if (digits <= 6) v = v * 16 + hexval(line[i]);
         end else if (line[i] != 8'h0D) begin
            bad = 1;
         end
      end
      line.delete();
      if (digits == 0 && !bad) return;
      if (digits == 6 && !bad) begin
         tx_exp.push_back(8'h4B);
         col_exp.push_back({8'(v), 8'(v >> 8), 8'(v >> 16)});
      end else begin
         tx_exp.push_back(8'h45);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic r;
      int waited;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
      rx_data = b; rx_valid = 1'b1;
      waited = 0; r = 1'b0;
      while (!r && waited < 1000) begin
         @(negedge clk); r = rx_ready;
         @(posedge clk); #1; waited++;
      end
      rx_valid = 1'b0;
      if (!r) begin
         vectors++; miscompares++;
         $display("FAIL accept_wait: byte %h not accepted after %0d cycles", b, waited);
      end else begin
         model_byte(b, cyc);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((tx_exp.size() != 0 || tx_valid) && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 2000) begin
         vectors++; miscompares++;
         $display("FAIL drain: %0d ACKs still pending, expected 0", tx_exp.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic set_mode(input int m);
      rdy_mode = m;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // tx_ready driver
   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the scoreboard on every transfer and colour strobe
   initial begin
      logic       pv;
      logic [7:0] pd;
      pv = 1'b0; pd = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0;
         end else begin
            if (pv) begin
               check("tx_hold_valid", 32'(tx_valid), 32'd1);
               check("tx_hold_data", 32'(tx_data), 32'(pd));
            end
            if (tx_valid && tx_ready) begin
               if (tx_exp.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL tx_unexpected: got %h, expected no byte", tx_data);
               end else begin
                  check("tx_byte", 32'(tx_data), 32'(tx_exp.pop_front()));
               end
            end
            if (color_stb) begin
               if (col_exp.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL stb_unexpected: got color %h, expected no strobe", color);
               end else begin
                  check("color_at_stb", 32'(color), 32'(col_exp.pop_front()));
               end
            end
            pv = tx_valid && !tx_ready;
            pd = tx_data;
         end
      end
   end

   initial begin
      string hexc, badc;
      logic [7:0] q[$];
      int kind, n, g;
      hexc = "0123456789abcdefABCDEF";
      badc = "Gz -#x";

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_color", 32'(color), 32'd0);
      check("rst_stb", 32'(color_stb), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      rst = 1'b0;
      last_t = cyc;
      set_mode(1);

      send_str("FF8000\n");
      drain();
      check("t1_color", 32'(color), 32'h0080FF);

      send_str("ff8000\r\n");
      drain();
      check("t2_color", 32'(color), 32'h0080FF);

      send_str("12345\n");
      send_str("1234567\n");
      send_str("12G456\n");
      drain();
      check("t3_color", 32'(color), 32'h0080FF);

      send_str("\n");
      repeat (3) @(posedge clk);
      #1;
      check("t4_tx_valid", 32'(tx_valid), 32'd0);
      check("t4_rx_ready", 32'(rx_ready), 32'd1);

      set_mode(0);
      send_str("000001\n");
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("t5_valid", 32'(tx_valid), 32'd1);
         check("t5_data", 32'(tx_data), 32'h4B);
         check("t5_rx_ready", 32'(rx_ready), 32'd0);
      end
      @(posedge clk); #1;
      rdy_mode = 1;
      drain();
      check("t5_color", 32'(color), 32'h010000);
      check("t5_rx_ready_after", 32'(rx_ready), 32'd1);

      send_str("AB");
      send_byte(8'h43, 100);
      send_str("DEF01\n");
      drain();
      check("t6_timeout_color", 32'(color), 32'h01EFCD);

      send_str("12");
      send_byte(8'h33, 98);
      send_str("456\n");
      drain();
      check("t6_no_timeout_color", 32'(color), 32'h563412);

      set_mode(0);
      send_str("000002\n");
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_tx_valid", 32'(tx_valid), 32'd0);
      check("arst_color", 32'(color), 32'd0);
      check("arst_rx_ready", 32'(rx_ready), 32'd0);
      tx_exp.delete();
      line.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      last_t = cyc;

      rdy_mode = 2;
      for (int l = 0; l < 40; l++) begin
         q.delete();
         kind = $urandom_range(0, 5);
         n = (kind == 2) ? $urandom_range(1, 9) : 6;
         for (int i = 0; i < n; i++) q.push_back(hexc[$urandom_range(0, 21)]);
         if (kind == 1) q.insert($urandom_range(0, n), 8'h0D);
         if (kind == 3) q[$urandom_range(0, n - 1)] = badc[$urandom_range(0, 5)];
         if (kind == 4) q.delete();
         q.push_back(8'h0A);
         foreach (q[i]) begin
            g = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
            if (kind == 5 && i == 3) g = 130;
            send_byte(q[i], g);
         end
      end
      rdy_mode = 1;
      drain();
      check("end_tx_queue", 32'(tx_exp.size()), 32'd0);
      check("end_col_queue", 32'(col_exp.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
